// File: rtl/adder_pkg.sv
// Shared types and limits for the bit-serial adder.
// The optional overflow output of serial_adder is enabled by SERIAL_ADDER_OVF_EN.
package adder_pkg;

    localparam int SERIAL_ADDER_MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // A 1-bit operand still needs a 1-bit counter.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit combinational full adder; the bit slice reused by serial_adder.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder, LSB first, valid/ready on both sides.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// SHIFT | one operand bit per cycle through the full_adder, busy=1
// DONE  | sum/cout held with out_valid=1 until out_ready
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    if (WIDTH < 1 || WIDTH > SERIAL_ADDER_MAX_WIDTH) begin : g_bad_width
        $error("serial_adder: WIDTH out of range 1..32");
    end

    state_e           r_state;
    logic [WIDTH-1:0] r_opa_sr;
    logic [WIDTH-1:0] r_opb_sr;
    logic [WIDTH-1:0] r_sum_sr;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             r_busy;
    logic             w_fa_sum;
    logic             w_fa_cout;
    logic [WIDTH-1:0] w_sum_next;

    full_adder u_fa (
        .i_a    (r_opa_sr[0]),
        .i_b    (r_opb_sr[0]),
        .i_cin  (r_carry),
        .o_sum  (w_fa_sum),
        .o_cout (w_fa_cout)
    );

    // New bit enters at the MSB so the final shift leaves bit 0 in place.
    always_comb begin
        w_sum_next             = r_sum_sr >> 1;
        w_sum_next[WIDTH-1]    = w_fa_sum;
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;
    assign ovf = r_ovf;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_opa_sr    <= '0;
            r_opb_sr    <= '0;
            r_sum_sr    <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_opa_sr   <= a;
                        r_opb_sr   <= b;
                        r_carry    <= cin;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_opa_sr <= r_opa_sr >> 1;
                    r_opb_sr <= r_opb_sr >> 1;
                    r_sum_sr <= w_sum_next;
                    r_carry  <= w_fa_cout;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST_BIT) begin
                        r_sum       <= w_sum_next;
                        r_cout      <= w_fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        // r_carry is the carry into the MSB on this last step.
                        r_ovf       <= r_carry ^ w_fa_cout;
`endif
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 and WIDTH=1 instances checked against a+b+cin.
// Overflow checks are compiled in when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

    typedef struct {
        longint s;
        logic   co;
        logic   ov;
        longint acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       in_valid, in_ready, cin, out_valid, out_ready, cout, busy, ovf;
    logic [7:0] a, b, sum;
    logic       in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, busy1, ovf1;
    logic [0:0] a1, b1, sum1;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .busy(busy1)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf1)
`endif
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf  = 1'b0;
    assign ovf1 = 1'b0;
`endif

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;
    exp_t   sb8[$];
    exp_t   sb1[$];
    int     rmode8   = 1;   // 0 hold low, 1 always ready, 2 random
    longint last_acc8 = 0, last_drain8 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Reference: plain integer arithmetic on the unsigned and signed views of the operands.
    function automatic exp_t model(input int w, input longint x, input longint y,
                                   input longint ci, input longint acc);
        exp_t   r;
        longint m  = longint'(1) << w;
        longint h  = m / 2;
        longint tot = x + y + ci;
        longint sx = (x >= h) ? x - m : x;
        longint sy = (y >= h) ? y - m : y;
        longint ss = sx + sy + ci;
        r.s   = tot % m;
        r.co  = (tot / m) != 0;
        r.ov  = (ss > h - 1) || (ss < -h);
        r.acc = acc;
        return r;
    endfunction

    // Input monitors: a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            sb8.push_back(model(8, longint'(a), longint'(b), longint'(cin), cyc + 1));
            last_acc8 = cyc + 1;
        end
        if (!rst && in_valid1 && in_ready1)
            sb1.push_back(model(1, longint'(a1), longint'(b1), longint'(cin1), cyc + 1));
    end

    exp_t cur8, cur1;
    bit   prev8 = 0, prev1 = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev8 = 0;
        end else begin
            if (out_valid) begin
                if (!prev8) begin
                    if (sb8.size() == 0) fail_now("unexpected_out_valid8");
                    else begin
                        cur8 = sb8.pop_front();
                        check("latency8", 64'(cyc - cur8.acc), 64'd8);
                    end
                end
                check("sum8", 64'(sum), 64'(cur8.s));
                check("cout8", 64'(cout), 64'(cur8.co));
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf8", 64'(ovf), 64'(cur8.ov));
`endif
                check("in_ready_in_done8", 64'(in_ready), 64'd0);
                if (out_ready) last_drain8 = cyc + 1;
            end
            prev8 = out_valid;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev1 = 0;
        end else begin
            if (out_valid1) begin
                if (!prev1) begin
                    if (sb1.size() == 0) fail_now("unexpected_out_valid1");
                    else begin
                        cur1 = sb1.pop_front();
                        check("latency1", 64'(cyc - cur1.acc), 64'd1);
                    end
                end
                check("sum1", 64'(sum1), 64'(cur1.s));
                check("cout1", 64'(cout1), 64'(cur1.co));
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf1", 64'(ovf1), 64'(cur1.ov));
`endif
            end
            prev1 = out_valid1;
        end
    end

    always @(posedge clk) begin
        #2;
        case (rmode8)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Called at posedge+2; returns at posedge+2 after the accepting edge.
    task automatic send8(input logic [7:0] x, input logic [7:0] y, input logic ci);
        int k = 0;
        a = x; b = y; cin = ci; in_valid = 1'b1;
        do begin @(negedge clk); k++; end while (!in_ready && k < 200);
        if (!in_ready) fail_now("send8_timeout");
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic send1(input logic x, input logic y, input logic ci);
        int k = 0;
        a1 = x; b1 = y; cin1 = ci; in_valid1 = 1'b1;
        do begin @(negedge clk); k++; end while (!in_ready1 && k < 50);
        if (!in_ready1) fail_now("send1_timeout");
        @(posedge clk); #2;
        in_valid1 = 1'b0;
    endtask

    task automatic wait_valid8(input logic [7:0] es, input logic ec, input logic eo);
        int k = 0;
        do begin @(negedge clk); k++; end while (!out_valid && k < 100);
        if (!out_valid) fail_now("wait_valid8_timeout");
        else begin
            check("dir_sum", 64'(sum), 64'(es));
            check("dir_cout", 64'(cout), 64'(ec));
`ifdef SERIAL_ADDER_OVF_EN
            check("dir_ovf", 64'(ovf), 64'(eo));
`endif
        end
        @(posedge clk); #2;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_sum"}, 64'(sum), 64'd0);
        check({tag, "_cout"}, 64'(cout), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, 64'(ovf), 64'd0);
`endif
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        check("por_in_ready1", 64'(in_ready1), 64'd1);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;

        send8(8'h5A, 8'h3C, 1'b1);
        wait_valid8(8'h97, 1'b0, 1'b1);

        // Reset two cycles into SHIFT discards the add and clears the previous 0x97.
        send8(8'h33, 8'h44, 1'b0);
        repeat (2) begin @(posedge clk); #2; end
        check("midop_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check_reset("midop");
        sb8.delete();
        @(posedge clk); #2;
        rst = 1'b0;

        send8(8'hFF, 8'h01, 1'b0);
        wait_valid8(8'h00, 1'b1, 1'b0);

        // Backpressure with a second request already waiting.
        rmode8 = 0;
        @(posedge clk); #2;
        send8(8'h80, 8'h80, 1'b0);
        fork
            send8(8'h11, 8'h22, 1'b1);
            begin
                int k = 0;
                do begin @(negedge clk); k++; end while (!out_valid && k < 100);
                if (!out_valid) fail_now("bp_valid_timeout");
                repeat (5) begin
                    check("bp_valid_held", 64'(out_valid), 64'd1);
                    check("bp_sum", 64'(sum), 64'h00);
                    check("bp_cout", 64'(cout), 64'd1);
`ifdef SERIAL_ADDER_OVF_EN
                    check("bp_ovf", 64'(ovf), 64'd1);
`endif
                    @(negedge clk);
                end
                rmode8 = 1;
            end
        join
        check("bp_accept_after_drain", 64'(last_acc8), 64'(last_drain8 + 1));
        wait_valid8(8'h34, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            send1(v[2], v[1], v[0]);
        end

        rmode8 = 2;
        for (int i = 0; i < 1000; i++)
            send8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        rmode8 = 1;

        begin
            int k = 0;
            while ((sb8.size() != 0 || sb1.size() != 0 || out_valid || out_valid1) && k < 200) begin
                @(negedge clk);
                k++;
            end
            if (sb8.size() != 0 || sb1.size() != 0) fail_now("results_missing");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
